// File: rtl/ifu_axil_fetch_if.sv
// AXI4-Lite read-channel bundle between the instruction fetch unit (master)
// and the instruction memory or bus (slave). Only AR and R channels exist,
// because the fetch unit never writes.
interface ifu_axil_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ifu_axil_fetch.sv
// Instruction fetch unit: turns each PC update into one AXI4-Lite read and
// presents the returned word to decode over a valid/ready handshake.
// FSM: IDLE -> ADDR (AR in flight) -> DATA (waiting for R) -> HOLD (offer to
// decode). A decode handshake in HOLD that coincides with fetch_req goes
// straight back to ADDR, so consecutive fetches need no idle cycle.
// All outputs come straight from flops.
//
// Optional build macro IFU_FAULT_EN: adds a 'fault' output. A misaligned pc
// completes immediately as a faulting fetch without touching the bus, and a
// non-OKAY rresp replaces the instruction with zero and raises fault. Without
// the macro the low pc bits are masked off araddr and rresp is ignored.
module ifu_axil_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  ifu_axil_fetch_if.master      axi,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  fetch_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`ifdef IFU_FAULT_EN
  ,
  output logic                  fault
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] araddr, araddr_d;
  logic                  arvalid, arvalid_d;
  logic                  rready, rready_d;
  logic [DATA_WIDTH-1:0] inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_d;
  logic                  valid_d;
  logic                  busy_d;
  logic [CNT_WIDTH-1:0]  fetch_cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_d;
  logic                  start;
`ifdef IFU_FAULT_EN
  logic                  fault_d;
`endif

  assign axi.araddr  = araddr;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  // Next-state and next-output logic for every register of the block.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and turn it into a latch.
    state_d     = state;
    araddr_d    = araddr;
    arvalid_d   = arvalid;
    rready_d    = rready;
    inst_d      = inst;
    inst_pc_d   = inst_pc;
    valid_d     = valid;
    fetch_cnt_d = fetch_cnt;
    stall_cnt_d = stall_cnt;
    start       = 1'b0;
`ifdef IFU_FAULT_EN
    fault_d     = fault;
`endif

    if (state == ADDR || state == DATA) begin
      stall_cnt_d = stall_cnt + CNT_WIDTH'(1);
    end

    unique case (state)
      IDLE: begin
        if (fetch_req) begin
          start = 1'b1;
        end
      end
      ADDR: begin
        // fetch_req here is a protocol violation and is dropped.
        if (arvalid && axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        // rready is still low in the AR handshake cycle, so an early rvalid
        // is simply not taken.
        if (axi.rvalid && rready) begin
          inst_d   = axi.rdata;
          rready_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = HOLD;
`ifdef IFU_FAULT_EN
          if (axi.rresp != 2'b00) begin
            inst_d  = '0;
            fault_d = 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        // Without ready, inst/inst_pc hold and fetch_req is dropped.
        if (valid && ready) begin
          valid_d     = 1'b0;
          fetch_cnt_d = fetch_cnt + CNT_WIDTH'(1);
          state_d     = IDLE;
`ifdef IFU_FAULT_EN
          fault_d     = 1'b0;
`endif
          if (fetch_req) begin
            start = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepting a fetch overrides whatever the state case chose above.
    if (start) begin
      inst_pc_d = pc;
`ifdef IFU_FAULT_EN
      if (pc[1:0] != 2'b00) begin
        // Misaligned: finish immediately as a faulting fetch, no bus access.
        inst_d    = '0;
        valid_d   = 1'b1;
        fault_d   = 1'b1;
        arvalid_d = 1'b0;
        state_d   = HOLD;
      end else begin
        araddr_d  = {pc[ADDR_WIDTH-1:2], 2'b00};
        arvalid_d = 1'b1;
        state_d   = ADDR;
      end
`else
      araddr_d  = {pc[ADDR_WIDTH-1:2], 2'b00};
      arvalid_d = 1'b1;
      state_d   = ADDR;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      inst      <= '0;
      inst_pc   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      fetch_cnt <= '0;
      stall_cnt <= '0;
`ifdef IFU_FAULT_EN
      fault     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      araddr    <= araddr_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      inst      <= inst_d;
      inst_pc   <= inst_pc_d;
      valid     <= valid_d;
      busy      <= busy_d;
      fetch_cnt <= fetch_cnt_d;
      stall_cnt <= stall_cnt_d;
`ifdef IFU_FAULT_EN
      fault     <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifu_axil_fetch.sv
// Testbench for ifu_axil_fetch: a cycle-by-cycle vector table for the basic
// and back-to-back fetch flows, followed by hand-written sequences for long
// bus stalls, decode back-pressure, reset mid-transaction and the pc/rresp
// corner cases of whichever build is compiled.
module tb_ifu_axil_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        valid;
  logic        ready;
  logic        busy;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`ifdef IFU_FAULT_EN
  logic        fault;
`endif

  int total = 0;
  int bad   = 0;

  ifu_axil_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ifu_axil_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .pc        (pc),
    .axi       (bus),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`ifdef IFU_FAULT_EN
    ,
    .fault     (fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic [31:0] pc;
    logic        ar;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_arv;
    logic        e_rr;
    logic        e_v;
    logic        e_busy;
    logic [31:0] e_araddr;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic [31:0] e_fcnt;
    logic [31:0] e_scnt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and new inputs
  // are driven at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vcount;

    // fr pc ar rv rd rdy | arv rr v busy araddr inst inst_pc fcnt scnt
    // Basic fetch: fetch_req -> ADDR -> DATA -> HOLD (valid on 3rd edge).
    vecs[0]  = '{1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0,         1'b1,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0,         32'h8000_0000, 32'd0, 32'd0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1,
                 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h0,         32'h8000_0000, 32'd0, 32'd1};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0010_0513, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0010_0513, 32'h8000_0000, 32'd0, 32'd2};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0010_0513, 32'h8000_0000, 32'd1, 32'd2};
    // rvalid during the AR handshake cycle is not taken.
    vecs[4]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0010_0513, 32'h0000_1000, 32'd1, 32'd2};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h1111_1111, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h0010_0513, 32'h0000_1000, 32'd1, 32'd3};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000, 32'd1, 32'd4};
    // Back-to-back: handshake plus fetch_req in HOLD goes straight to ADDR.
    vecs[7]  = '{1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0,         1'b1,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_2000, 32'd2, 32'd4};
    // fetch_req while in ADDR is ignored.
    vecs[8]  = '{1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0,         1'b0,
                 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_2000, 32'd2, 32'd5};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0000_2000, 32'd2, 32'd6};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h1234_5678, 32'h0000_2000, 32'd3, 32'd6};

    rst         = 1'b1;
    fetch_req   = 1'b0;
    pc          = '0;
    ready       = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;

    // Reset for two cycles, then one idle cycle.
    step();
    step();
    rst = 1'b0;
    step();
    check("rst arvalid", bus.arvalid, 0);
    check("rst rready", bus.rready, 0);
    check("rst valid", valid, 0);
    check("rst busy", busy, 0);
    check("rst araddr", bus.araddr, 0);
    check("rst inst", inst, 0);
    check("rst inst_pc", inst_pc, 0);
    check("rst fetch_cnt", fetch_cnt, 0);
    check("rst stall_cnt", stall_cnt, 0);
`ifdef IFU_FAULT_EN
    check("rst fault", fault, 0);
`endif

    // Table-driven flows.
    for (int i = 0; i < 11; i++) begin
      fetch_req   = vecs[i].fr;
      pc          = vecs[i].pc;
      bus.arready = vecs[i].ar;
      bus.rvalid  = vecs[i].rv;
      bus.rdata   = vecs[i].rd;
      ready       = vecs[i].rdy;
      step();
      check($sformatf("vec%0d arvalid", i), bus.arvalid, vecs[i].e_arv);
      check($sformatf("vec%0d rready", i), bus.rready, vecs[i].e_rr);
      check($sformatf("vec%0d valid", i), valid, vecs[i].e_v);
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d araddr", i), bus.araddr, vecs[i].e_araddr);
      check($sformatf("vec%0d inst", i), inst, vecs[i].e_inst);
      check($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
      check($sformatf("vec%0d fetch_cnt", i), fetch_cnt, vecs[i].e_fcnt);
      check($sformatf("vec%0d stall_cnt", i), stall_cnt, vecs[i].e_scnt);
    end
    fetch_req  = 1'b0;
    bus.rvalid = 1'b0;
    ready      = 1'b0;

    // Long stalls: arready after 4 wait cycles (5 in ADDR), rvalid after 3
    // wait cycles (4 in DATA): stall_cnt grows by 9.
    vcount      = 0;
    ready       = 1'b1;
    fetch_req   = 1'b1;
    pc          = 32'h8000_0010;
    bus.arready = 1'b0;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stall addr%0d arvalid", i), bus.arvalid, 1);
      check($sformatf("stall addr%0d araddr", i), bus.araddr, 32'h8000_0010);
    end
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall data%0d rready", i), bus.rready, 1);
      if (valid) vcount++;
    end
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hCAFE_F00D;
    step();
    check("stall inst", inst, 32'hCAFE_F00D);
    if (valid) vcount++;
    bus.rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (valid) vcount++;
    end
    check("stall valid pulses", vcount, 1);
    check("stall stall_cnt", stall_cnt, 32'd15);
    check("stall fetch_cnt", fetch_cnt, 32'd4);
    check("stall inst_pc", inst_pc, 32'h8000_0010);

    // Decode back-pressure in HOLD with a stray fetch_req, then a handshake
    // together with a new fetch_req.
    ready       = 1'b0;
    fetch_req   = 1'b1;
    pc          = 32'h8000_0020;
    bus.arready = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'hAAAA_5555;
    step();
    bus.rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_req = (i == 2);
      pc        = (i == 2) ? 32'h9000_0000 : 32'h0;
      step();
      check($sformatf("hold%0d valid", i), valid, 1);
      check($sformatf("hold%0d inst", i), inst, 32'hAAAA_5555);
      check($sformatf("hold%0d inst_pc", i), inst_pc, 32'h8000_0020);
    end
    ready     = 1'b1;
    fetch_req = 1'b1;
    pc        = 32'h8000_0004;
    step();
    fetch_req = 1'b0;
    check("b2b arvalid", bus.arvalid, 1);
    check("b2b araddr", bus.araddr, 32'h8000_0004);
    check("b2b valid", valid, 0);
    check("b2b busy", busy, 1);
    check("b2b fetch_cnt", fetch_cnt, 32'd5);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h0000_0013;
    step();
    bus.rvalid = 1'b0;
    step();
    check("b2b done busy", busy, 0);
    check("b2b done fetch_cnt", fetch_cnt, 32'd6);

    // Reset while in DATA, then a stray rvalid.
    ready       = 1'b1;
    fetch_req   = 1'b1;
    pc          = 32'h0000_3000;
    bus.arready = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    bus.arready = 1'b0;
    check("mid rready before rst", bus.rready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rready", bus.rready, 0);
    check("mid busy", busy, 0);
    check("mid fetch_cnt", fetch_cnt, 0);
    check("mid stall_cnt", stall_cnt, 0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h0000_0BAD;
    vcount     = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (valid) vcount++;
      check($sformatf("stray%0d rready", i), bus.rready, 0);
    end
    bus.rvalid = 1'b0;
    check("stray valid count", vcount, 0);
    check("stray inst", inst, 0);

`ifdef IFU_FAULT_EN
    // Misaligned pc: no AR, immediate faulting HOLD.
    ready     = 1'b0;
    fetch_req = 1'b1;
    pc        = 32'h8000_0002;
    step();
    fetch_req = 1'b0;
    check("mis arvalid", bus.arvalid, 0);
    check("mis valid", valid, 1);
    check("mis fault", fault, 1);
    check("mis inst", inst, 0);
    check("mis inst_pc", inst_pc, 32'h8000_0002);
    ready = 1'b1;
    step();
    check("mis clr valid", valid, 0);
    check("mis clr fault", fault, 0);
    // Error response on the R channel.
    ready       = 1'b0;
    fetch_req   = 1'b1;
    pc          = 32'h8000_0008;
    bus.arready = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h1234_5678;
    bus.rresp   = 2'b10;
    step();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    check("slverr valid", valid, 1);
    check("slverr fault", fault, 1);
    check("slverr inst", inst, 0);
    ready = 1'b1;
    step();
    check("slverr clr fault", fault, 0);
    check("slverr fetch_cnt", fetch_cnt, 32'd2);
`else
    // Misaligned pc is masked on araddr; rresp is ignored.
    ready       = 1'b1;
    fetch_req   = 1'b1;
    pc          = 32'h8000_0007;
    bus.arready = 1'b1;
    step();
    fetch_req = 1'b0;
    check("mask araddr", bus.araddr, 32'h8000_0004);
    check("mask inst_pc", inst_pc, 32'h8000_0007);
    step();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h55AA_55AA;
    bus.rresp   = 2'b10;
    step();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    check("mask valid", valid, 1);
    check("mask inst", inst, 32'h55AA_55AA);
    step();
    check("mask fetch_cnt", fetch_cnt, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_axil_fetch.md
Name: ifu_axil_fetch

Overview:
Instruction fetch unit between the PC register and the decode-stage pipeline register. On each PC update it issues one AXI4-Lite read for the instruction word and captures the returned data. It then presents pc/inst to decode through a valid/ready handshake. It replaces the combinational instruction memory so that variable-latency memories and buses can be attached.

Parameters:
ADDR_WIDTH, 32, width of pc and araddr
DATA_WIDTH, 32, width of rdata and inst (only 32 supported)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
fetch_req  input  1  one-cycle pulse: pc has just been updated, fetch it
pc  input  ADDR_WIDTH  fetch address; sampled only when fetch_req is accepted
araddr  output  ADDR_WIDTH  AXI-Lite read address
arvalid  output  1  read address valid
arready  input  1  read address ready
rdata  input  DATA_WIDTH  read data
rresp  input  2  read response
rvalid  input  1  read data valid
rready  output  1  read data ready
inst  output  DATA_WIDTH  fetched instruction
inst_pc  output  ADDR_WIDTH  pc of the instruction held on inst
valid  output  1  inst/inst_pc valid toward decode
ready  input  1  decode can accept
busy  output  1  high in any state other than IDLE
fetch_cnt  output  CNT_WIDTH  number of completed decode handshakes
stall_cnt  output  CNT_WIDTH  number of cycles spent in ADDR or DATA

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; arvalid=0, rready=0, valid=0.
  - araddr=0, inst=0, inst_pc=0, fetch_cnt=0, stall_cnt=0.
  - Reset mid-transaction abandons it; any later rvalid is ignored because rready=0.
- All outputs are registered. Sequence: fetch_req edge -> arvalid high the next cycle. Minimum latency fetch_req to valid is 3 cycles when arready=1 and rvalid arrives the cycle after the AR handshake.
- IDLE:
  - On fetch_req: araddr<={pc[ADDR_WIDTH-1:2],2'b00}, inst_pc<=pc, arvalid<=1, go to ADDR.
- ADDR:
  - arvalid and araddr stay stable until arready.
  - On arvalid&arready: arvalid<=0, rready<=1, go to DATA.
- DATA:
  - On rvalid&rready: inst<=rdata, rready<=0, valid<=1, go to HOLD.
  - rvalid in the same cycle as the AR handshake is not accepted, because rready is still 0.
- HOLD:
  - valid stays high; inst and inst_pc stay stable until ready.
  - On valid&ready: valid<=0 and fetch_cnt+=1 (wraps at 2^CNT_WIDTH).
  - If fetch_req is also high that cycle, load the new pc and go to ADDR (back-to-back fetch). Otherwise go to IDLE.
- fetch_req in ADDR or DATA is a protocol violation: it is ignored and pc is not resampled. fetch_req in HOLD without ready is also ignored.
- stall_cnt increments every cycle the state is ADDR or DATA, and wraps.
- busy = (state != IDLE), registered with the state.

Optional Feature:
IFU_FAULT_EN.
- Defined:
  - Adds an output port fault (1 bit, reset 0), valid when valid=1.
  - pc[1:0]!=0 on an accepted fetch_req: no AR is issued; the next state is HOLD with valid=1, fault=1, inst=0.
  - rresp!=2'b00 on the R handshake: inst=0, fault=1.
  - fault clears on the valid&ready handshake.
- Undefined:
  - No fault port.
  - pc[1:0] is silently masked in araddr; inst_pc keeps the full pc.
  - rresp is ignored and rdata is always captured.

Test Plan:
1. rst=1 for 2 cycles, then release -> arvalid=0, rready=0, valid=0, busy=0, fetch_cnt=0, stall_cnt=0.
2. fetch_req with pc=0x80000000; arready=1; rvalid the next cycle with rdata=0x00100513; ready=1 -> valid on cycle 3, inst=0x00100513, inst_pc=0x80000000, fetch_cnt=1.
3. arready delayed 4 cycles, rvalid delayed 3 cycles -> araddr stable during the wait, stall_cnt=9 (5 cycles in ADDR + 4 in DATA), single valid pulse.
4. ready=0 for 5 cycles in HOLD, with a fetch_req pulse injected -> inst held, pulse ignored. Then ready=1 together with fetch_req pc=0x80000004 -> state ADDR next cycle, araddr=0x80000004.
5. Reset asserted while in DATA, followed by a stray rvalid -> returns to IDLE, rready=0, valid never asserts.
6. IFU_FAULT_EN: pc=0x80000002 -> no arvalid, valid=1 with fault=1, inst=0. rresp=2'b10 on a normal fetch -> fault=1, inst=0.
